homography_arbiter: RTL and testbench

Shares one homography lookup engine between two pixel-stream requesters (two sync controllers driving independent display halves). Arbitrates query issue round-robin, tracks in-flight queries in an internal tag FIFO, and routes the engine's in-order results back to the requester that issued them. Also provides a drain/flush handshake for frame boundaries and sticky error flags for protocol checking.

---
 rtl/homography_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_homography_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/homography_arbiter.sv
// -----------------------------------------------------------------------------
// homography_arbiter
//
// Two pixel-stream requesters share a single homography lookup engine through
// this block. It issues queries to the engine round-robin, keeps every
// in-flight query in a tag FIFO, and steers the engine's in-order results back
// to whichever requester issued them. There is also a flush/drain handshake
// for frame boundaries, and there are sticky protocol error flags.
//
// Ports
//   clk_25, rst_n                 clock, asynchronous active-low reset
//   req_valid_k, req_x_k, req_y_k requester k query (k = 0, 1)
//   req_ready_k                   combinational grant to requester k
//   query_x, query_y, start       registered query issued to the engine
//   ready, return_x/y, r, g, b    engine result, in issue order
//   rsp_valid_k                   registered result strobe for requester k
//   rsp_x/y, rsp_r/g/b            registered shared response bus
//   flush_req, flush_done         drain request (level) / drained pulse
//   busy                          any query in flight (registered)
//   err_underflow, err_mismatch   sticky protocol error flags
// -----------------------------------------------------------------------------
module homography_arbiter #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic       clk_25,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic [9:0] req_x_0,
  input  logic [9:0] req_y_0,
  output logic       req_ready_0,
  input  logic       req_valid_1,
  input  logic [9:0] req_x_1,
  input  logic [9:0] req_y_1,
  output logic       req_ready_1,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  output logic       start,
  input  logic       ready,
  input  logic [9:0] return_x,
  input  logic [9:0] return_y,
  input  logic [4:0] r,
  input  logic [5:0] g,
  input  logic [4:0] b,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  output logic [9:0] rsp_x,
  output logic [9:0] rsp_y,
  output logic [4:0] rsp_r,
  output logic [5:0] rsp_g,
  output logic [4:0] rsp_b,
  input  logic       flush_req,
  output logic       flush_done,
  output logic       busy,
  output logic       err_underflow,
  output logic       err_mismatch
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [PTR_W:0]   L_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   L_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] L_PTR_ONE = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [20:0]      r_fifo [DEPTH];   // {tag, x[9:0], y[9:0]}
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_last_grant;

  logic [9:0]       r_query_x;
  logic [9:0]       r_query_y;
  logic             r_start;
  logic             r_rsp_valid_0;
  logic             r_rsp_valid_1;
  logic [9:0]       r_rsp_x;
  logic [9:0]       r_rsp_y;
  logic [4:0]       r_rsp_r;
  logic [5:0]       r_rsp_g;
  logic [4:0]       r_rsp_b;
  logic             r_flush_done;
  logic             r_busy;
  logic             r_err_underflow;
  logic             r_err_mismatch;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  logic             w_grant_en;
  logic             w_sel;
  logic             w_push;
  logic             w_pop;
  logic [9:0]       w_sel_x;
  logic [9:0]       w_sel_y;
  logic [20:0]      w_head;
  logic             w_head_tag;
  logic [9:0]       w_head_x;
  logic [9:0]       w_head_y;
  logic [PTR_W:0]   w_count_nxt;

  // flush_req gates grants in the very cycle it rises, before the FSM has
  // moved to S_DRAIN. A full FIFO blocks grants even when a pop happens in
  // the same cycle; there is no bypass.
  assign w_grant_en = (r_state == S_RUN) && !flush_req && (r_count < L_DEPTH);

  // On a tie the port that did not win last time is chosen. Otherwise the
  // only valid port is chosen.
  assign w_sel   = (req_valid_0 && req_valid_1) ? ~r_last_grant : req_valid_1;
  assign w_sel_x = w_sel ? req_x_1 : req_x_0;
  assign w_sel_y = w_sel ? req_y_1 : req_y_0;

  assign req_ready_0 = w_grant_en && req_valid_0 && !w_sel;
  assign req_ready_1 = w_grant_en && req_valid_1 &&  w_sel;

  assign w_push = req_ready_0 || req_ready_1;
  assign w_pop  = ready && (r_count != '0);

  assign w_head     = r_fifo[r_rd_ptr];
  assign w_head_tag = w_head[20];
  assign w_head_x   = w_head[19:10];
  assign w_head_y   = w_head[9:0];

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + L_CNT_ONE;
      2'b01:   w_count_nxt = r_count - L_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tag FIFO storage. The contents need no reset because r_count governs
  // which entries are valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {w_sel, w_sel_x, w_sel_y};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: pointers, occupancy, issue, response and error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_last_grant    <= 1'b1;
      r_query_x       <= '0;
      r_query_y       <= '0;
      r_start         <= 1'b0;
      r_rsp_valid_0   <= 1'b0;
      r_rsp_valid_1   <= 1'b0;
      r_rsp_x         <= '0;
      r_rsp_y         <= '0;
      r_rsp_r         <= '0;
      r_rsp_g         <= '0;
      r_rsp_b         <= '0;
      r_busy          <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_mismatch  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_busy  <= (w_count_nxt != '0);

      // Issue
      r_start <= w_push;
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + L_PTR_ONE;
        r_last_grant <= w_sel;
        r_query_x    <= w_sel_x;
        r_query_y    <= w_sel_y;
      end

      // Response: route the head entry to its requester. The bus holds its
      // last value whenever no strobe is raised.
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + L_PTR_ONE;
        r_rsp_valid_0 <= !w_head_tag;
        r_rsp_valid_1 <=  w_head_tag;
        r_rsp_x       <= w_head_x;
        r_rsp_y       <= w_head_y;
        r_rsp_r       <= r;
        r_rsp_g       <= g;
        r_rsp_b       <= b;
        if ((return_x != w_head_x) || (return_y != w_head_y)) begin
          r_err_mismatch <= 1'b1;
        end
      end else begin
        r_rsp_valid_0 <= 1'b0;
        r_rsp_valid_1 <= 1'b0;
      end

      if (ready && (r_count == '0)) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Flush FSM. S_DONE also serves as the post-drain hold: it stays there
  // while flush_req remains high, without repeating flush_done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (flush_req) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_count_nxt == '0) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end
        end
        S_DONE: begin
          if (!flush_req) begin
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign query_x       = r_query_x;
  assign query_y       = r_query_y;
  assign start         = r_start;
  assign rsp_valid_0   = r_rsp_valid_0;
  assign rsp_valid_1   = r_rsp_valid_1;
  assign rsp_x         = r_rsp_x;
  assign rsp_y         = r_rsp_y;
  assign rsp_r         = r_rsp_r;
  assign rsp_g         = r_rsp_g;
  assign rsp_b         = r_rsp_b;
  assign flush_done    = r_flush_done;
  assign busy          = r_busy;
  assign err_underflow = r_err_underflow;
  assign err_mismatch  = r_err_mismatch;

endmodule

// File: tb/tb_homography_arbiter.sv
// -----------------------------------------------------------------------------
// tb_homography_arbiter
//
// Directed bench for homography_arbiter. Inputs change on the falling edge,
// and outputs are sampled on the falling edge. Combinational grants are
// sampled #1 after the inputs are driven.
// -----------------------------------------------------------------------------
module tb_homography_arbiter;

  logic       clk_25 = 1'b0;
  logic       rst_n;
  logic       req_valid_0, req_valid_1;
  logic [9:0] req_x_0, req_y_0, req_x_1, req_y_1;
  logic       req_ready_0, req_ready_1;
  logic [9:0] query_x, query_y;
  logic       start;
  logic       ready;
  logic [9:0] return_x, return_y;
  logic [4:0] r, b;
  logic [5:0] g;
  logic       rsp_valid_0, rsp_valid_1;
  logic [9:0] rsp_x, rsp_y;
  logic [4:0] rsp_r, rsp_b;
  logic [5:0] rsp_g;
  logic       flush_req, flush_done, busy, err_underflow, err_mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  always #20 clk_25 = ~clk_25;

  homography_arbiter #(.DEPTH(8), .PTR_W(3)) dut (
    .clk_25(clk_25), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_x_0(req_x_0), .req_y_0(req_y_0), .req_ready_0(req_ready_0),
    .req_valid_1(req_valid_1), .req_x_1(req_x_1), .req_y_1(req_y_1), .req_ready_1(req_ready_1),
    .query_x(query_x), .query_y(query_y), .start(start),
    .ready(ready), .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .err_underflow(err_underflow), .err_mismatch(err_mismatch)
  );

  task automatic idle_inputs();
    req_valid_0 = 0; req_valid_1 = 0;
    req_x_0 = '0; req_y_0 = '0; req_x_1 = '0; req_y_1 = '0;
    ready = 0; return_x = '0; return_y = '0; r = '0; g = '0; b = '0;
    flush_req = 0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk_25);
    idle_inputs();
    rst_n = 0;
    @(negedge clk_25);
    @(negedge clk_25);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk_25);
    idle_inputs();
    rst_n = 0;
    @(negedge clk_25);
    n_tests++;
    if ({query_x, query_y, start, rsp_valid_0, rsp_valid_1} !== 23'd0) begin
      n_fail++; $display("FAIL reset_issue: got %h want 0", {query_x, query_y, start, rsp_valid_0, rsp_valid_1});
    end
    n_tests++;
    if ({rsp_x, rsp_y, rsp_r, rsp_g, rsp_b} !== 36'd0) begin
      n_fail++; $display("FAIL reset_rspbus: got %h want 0", {rsp_x, rsp_y, rsp_r, rsp_g, rsp_b});
    end
    n_tests++;
    if ({flush_done, busy, err_underflow, err_mismatch} !== 4'd0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {flush_done, busy, err_underflow, err_mismatch});
    end
    rst_n = 1;
    @(negedge clk_25);
    req_valid_1 = 1;
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1} !== 2'b01) begin
      n_fail++; $display("FAIL reset_grant1: got %b want 01", {req_ready_0, req_ready_1});
    end
    req_valid_1 = 0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk_25);
    req_valid_0 = 1; req_x_0 = 10'd5; req_y_0 = 10'd7;
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin
      n_fail++; $display("FAIL single_grant: got %b want 10", {req_ready_0, req_ready_1});
    end
    @(negedge clk_25);
    req_valid_0 = 0;
    n_tests++;
    if ({start, query_x, query_y, busy} !== {1'b1, 10'd5, 10'd7, 1'b1}) begin
      n_fail++; $display("FAIL single_issue: got start=%b q=(%0d,%0d) busy=%b want 1 (5,7) 1", start, query_x, query_y, busy);
    end
    @(negedge clk_25);
    n_tests++;
    if ({start, query_x} !== {1'b0, 10'd5}) begin
      n_fail++; $display("FAIL single_start_pulse: got start=%b qx=%0d want 0 5", start, query_x);
    end
    ready = 1; return_x = 10'd5; return_y = 10'd7; r = 5'd3; g = 6'd9; b = 5'd1;
    @(negedge clk_25);
    ready = 0;
    n_tests++;
    if ({rsp_valid_0, rsp_valid_1, rsp_x, rsp_y} !== {2'b10, 10'd5, 10'd7}) begin
      n_fail++; $display("FAIL single_rsp: got v=%b%b (%0d,%0d) want 10 (5,7)", rsp_valid_0, rsp_valid_1, rsp_x, rsp_y);
    end
    n_tests++;
    if ({rsp_r, rsp_g, rsp_b, err_mismatch, busy} !== {5'd3, 6'd9, 5'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_rgb: got rgb=(%0d,%0d,%0d) mis=%b busy=%b want (3,9,1) 0 0", rsp_r, rsp_g, rsp_b, err_mismatch, busy);
    end
    @(negedge clk_25);
    n_tests++;
    if ({rsp_valid_0, rsp_x, rsp_y} !== {1'b0, 10'd5, 10'd7}) begin
      n_fail++; $display("FAIL single_hold: got v=%b (%0d,%0d) want 0 (5,7)", rsp_valid_0, rsp_x, rsp_y);
    end
  endtask

  // Both ports valid for 8 cycles; the bench plays an engine with 3-cycle latency.
  task automatic test_round_robin();
    logic       dv [0:31];
    logic [9:0] dx [0:31];
    logic [9:0] dy [0:31];
    int         n_grant = 0;
    int         n_rsp   = 0;
    logic       exp_tag;
    do_reset();
    req_x_0 = 10'd10; req_y_0 = 10'd11; req_x_1 = 10'd20; req_y_1 = 10'd21;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_25);
      dv[c] = start; dx[c] = query_x; dy[c] = query_y;
      if (rsp_valid_0 || rsp_valid_1) begin
        exp_tag = n_rsp[0];
        n_tests++;
        if ({rsp_valid_0, rsp_valid_1, rsp_x, rsp_y} !==
            {~exp_tag, exp_tag, (exp_tag ? 10'd20 : 10'd10), (exp_tag ? 10'd21 : 10'd11)}) begin
          n_fail++; $display("FAIL rr_rsp%0d: got v=%b%b (%0d,%0d) want tag %0d", n_rsp, rsp_valid_0, rsp_valid_1, rsp_x, rsp_y, exp_tag);
        end
        n_rsp++;
      end
      req_valid_0 = (c < 8); req_valid_1 = (c < 8);
      if (c >= 3 && dv[c-3]) begin
        ready = 1; return_x = dx[c-3]; return_y = dy[c-3];
      end else begin
        ready = 0;
      end
      #1;
      if (c < 8) begin
        exp_tag = n_grant[0];
        n_tests++;
        if ({req_ready_0, req_ready_1} !== {~exp_tag, exp_tag}) begin
          n_fail++; $display("FAIL rr_grant%0d: got %b%b want %b%b", n_grant, req_ready_0, req_ready_1, ~exp_tag, exp_tag);
        end
        n_grant++;
      end
    end
    ready = 0;
    n_tests++;
    if (n_rsp != 8 || err_mismatch !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rr_count: got rsp=%0d mis=%b busy=%b want 8 0 0", n_rsp, err_mismatch, busy);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_25);
      req_valid_0 = 1; req_x_0 = 10'(i); req_y_0 = 10'(i + 100);
      #1;
      n_tests++;
      if (req_ready_0 !== 1'b1) begin
        n_fail++; $display("FAIL full_fill%0d: got %b want 1", i, req_ready_0);
      end
    end
    @(negedge clk_25);
    req_valid_1 = 1; req_x_1 = 10'd500; req_y_1 = 10'd501;
    ready = 1; return_x = 10'd0; return_y = 10'd100;
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1, busy} !== 3'b001) begin
      n_fail++; $display("FAIL full_block: got rdy=%b%b busy=%b want 00 1", req_ready_0, req_ready_1, busy);
    end
    @(negedge clk_25);
    ready = 0;
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1} !== 2'b01) begin
      n_fail++; $display("FAIL full_one_grant: got %b%b want 01", req_ready_0, req_ready_1);
    end
    n_tests++;
    if ({rsp_valid_0, rsp_x, rsp_y} !== {1'b1, 10'd0, 10'd100}) begin
      n_fail++; $display("FAIL full_rsp: got v=%b (%0d,%0d) want 1 (0,100)", rsp_valid_0, rsp_x, rsp_y);
    end
    @(negedge clk_25);
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1} !== 2'b00) begin
      n_fail++; $display("FAIL full_refull: got %b%b want 00", req_ready_0, req_ready_1);
    end
    req_valid_0 = 0; req_valid_1 = 0;
  endtask

  task automatic test_simul();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_25);
      req_valid_0 = 1; req_x_0 = 10'(i + 1); req_y_0 = 10'(i + 1);
    end
    @(negedge clk_25);
    req_x_0 = 10'd5; req_y_0 = 10'd5;
    ready = 1; return_x = 10'd1; return_y = 10'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_25);
      req_valid_0 = 0;
      n_tests++;
      if ({rsp_valid_0, rsp_x, busy} !== {1'b1, 10'(k + 1), 1'b1}) begin
        n_fail++; $display("FAIL simul_rsp%0d: got v=%b x=%0d busy=%b want 1 %0d 1", k, rsp_valid_0, rsp_x, busy, k + 1);
      end
      ready = 1; return_x = 10'(k + 2); return_y = 10'(k + 2);
    end
    @(negedge clk_25);
    ready = 0;
    n_tests++;
    if ({rsp_valid_0, rsp_x, busy, err_mismatch, err_underflow} !== {1'b1, 10'd5, 3'b000}) begin
      n_fail++; $display("FAIL simul_last: got v=%b x=%0d busy=%b mis=%b und=%b want 1 5 0 0 0", rsp_valid_0, rsp_x, busy, err_mismatch, err_underflow);
    end
  endtask

  task automatic test_errors();
    do_reset();
    @(negedge clk_25);
    req_valid_0 = 1; req_x_0 = 10'd9; req_y_0 = 10'd9;
    @(negedge clk_25);
    req_valid_0 = 0;
    ready = 1; return_x = 10'd10; return_y = 10'd9;
    @(negedge clk_25);
    n_tests++;
    if ({err_mismatch, rsp_valid_0, err_underflow} !== 3'b110) begin
      n_fail++; $display("FAIL err_mismatch_set: got mis=%b v=%b und=%b want 1 1 0", err_mismatch, rsp_valid_0, err_underflow);
    end
    return_x = 10'd9;
    @(negedge clk_25);
    ready = 0;
    n_tests++;
    if ({err_underflow, rsp_valid_0, rsp_valid_1, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL err_underflow_set: got und=%b v=%b%b busy=%b want 1 00 0", err_underflow, rsp_valid_0, rsp_valid_1, busy);
    end
    repeat (3) @(negedge clk_25);
    n_tests++;
    if ({err_mismatch, err_underflow} !== 2'b11) begin
      n_fail++; $display("FAIL err_sticky: got %b%b want 11", err_mismatch, err_underflow);
    end
    rst_n = 0;
    #1;
    n_tests++;
    if ({err_mismatch, err_underflow} !== 2'b00) begin
      n_fail++; $display("FAIL err_clear: got %b%b want 00", err_mismatch, err_underflow);
    end
    // A reset with queries in flight discards them, so a late result underflows.
    @(negedge clk_25);
    rst_n = 1;
    req_valid_0 = 1;
    @(negedge clk_25);
    @(negedge clk_25);
    req_valid_0 = 0;
    rst_n = 0;
    @(negedge clk_25);
    rst_n = 1;
    ready = 1; return_x = 10'd9; return_y = 10'd9;
    @(negedge clk_25);
    ready = 0;
    n_tests++;
    if ({err_underflow, rsp_valid_0, busy} !== 3'b100) begin
      n_fail++; $display("FAIL err_late_ready: got und=%b v=%b busy=%b want 1 0 0", err_underflow, rsp_valid_0, busy);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_25);
      req_valid_0 = 1; req_x_0 = 10'(i + 1); req_y_0 = 10'd0;
    end
    @(negedge clk_25);
    req_valid_1 = 1; flush_req = 1;
    #1;
    n_tests++;
    if ({req_ready_0, req_ready_1, busy} !== 3'b001) begin
      n_fail++; $display("FAIL flush_grant_drop: got rdy=%b%b busy=%b want 00 1", req_ready_0, req_ready_1, busy);
    end
    req_valid_1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_25);
      n_tests++;
      if ({flush_done, req_ready_0} !== 2'b00) begin
        n_fail++; $display("FAIL flush_drain%0d: got done=%b rdy0=%b want 0 0", k, flush_done, req_ready_0);
      end
      ready = 1; return_x = 10'(k + 1); return_y = 10'd0;
    end
    @(negedge clk_25);
    ready = 0;
    n_tests++;
    if ({flush_done, busy, err_mismatch} !== 3'b100) begin
      n_fail++; $display("FAIL flush_done_pulse: got done=%b busy=%b mis=%b want 1 0 0", flush_done, busy, err_mismatch);
    end
    @(negedge clk_25);
    #1;
    n_tests++;
    if ({flush_done, req_ready_0} !== 2'b00) begin
      n_fail++; $display("FAIL flush_hold: got done=%b rdy0=%b want 0 0", flush_done, req_ready_0);
    end
    flush_req = 0;
    @(negedge clk_25);
    #1;
    n_tests++;
    if ({req_ready_0, flush_done} !== 2'b10) begin
      n_fail++; $display("FAIL flush_resume: got rdy0=%b done=%b want 1 0", req_ready_0, flush_done);
    end
    req_valid_0 = 0;
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full();
    test_simul();
    test_errors();
    test_flush();
    @(negedge clk_25);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
